// File: rtl/sort_sched.sv
// sort_sched: packet-level scheduler that shares one sort engine among N_CH
// Avalon-ST requesters.
//
// A round-robin arbiter picks one requester per packet. That packet is
// streamed into the engine sink. No new grant is issued until the engine has
// emitted the whole sorted packet, which is returned on the src stream and
// tagged with the owning channel.
//
// Ports
//   clk_i, srst_i                  clock, synchronous active-low reset
//   req_data_i/_startofpacket_i/   per-channel requester streams, channel i
//   _endofpacket_i/_valid_i/       data at [i*DWIDTH +: DWIDTH]
//   req_ready_o
//   eng_*_o, eng_ready_i           stream into the engine sink
//   eng_*_i, eng_ready_o           sorted stream from the engine source
//   src_*_o, src_ready_i           output stream (passes through from engine)
//   src_channel_o                  channel that owns the current output packet
//   grant_o                        registered current grant
//   busy_o                         FSM is not idle
//   trunc_o                        one-cycle pulse after a packet was truncated
module sort_sched #(
  parameter  int N_CH        = 4,
  parameter  int DWIDTH      = 8,
  parameter  int MAX_PKT_LEN = 1024,
  localparam int CH_W        = $clog2(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [N_CH*DWIDTH-1:0] req_data_i,
  input  logic [N_CH-1:0]        req_startofpacket_i,
  input  logic [N_CH-1:0]        req_endofpacket_i,
  input  logic [N_CH-1:0]        req_valid_i,
  output logic [N_CH-1:0]        req_ready_o,
  output logic [DWIDTH-1:0]      eng_data_o,
  output logic                   eng_startofpacket_o,
  output logic                   eng_endofpacket_o,
  output logic                   eng_valid_o,
  input  logic                   eng_ready_i,
  input  logic [DWIDTH-1:0]      eng_data_i,
  input  logic                   eng_startofpacket_i,
  input  logic                   eng_endofpacket_i,
  input  logic                   eng_valid_i,
  output logic                   eng_ready_o,
  output logic [DWIDTH-1:0]      src_data_o,
  output logic                   src_startofpacket_o,
  output logic                   src_endofpacket_o,
  output logic                   src_valid_o,
  output logic [CH_W-1:0]        src_channel_o,
  input  logic                   src_ready_i,
  output logic [CH_W-1:0]        grant_o,
  output logic                   busy_o,
  output logic                   trunc_o
);

  // Counter holds 0..MAX_PKT_LEN, so it can never wrap.
  localparam int               CNT_W    = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE_S, FWD_S, DROP_S, DRAIN_S} state_t;

  state_t           state;
  logic [CH_W-1:0]  last_grant;
  logic [CNT_W-1:0] cnt;

  logic [N_CH-1:0]  cand;
  logic [CH_W-1:0]  winner;
  logic             found;
  logic             g_valid;
  logic             g_eop;
  logic             fwd_xfer;
  logic             out_last;

  assign cand     = req_valid_i & req_startofpacket_i;
  assign g_valid  = req_valid_i[grant_o];
  assign g_eop    = req_endofpacket_i[grant_o];
  assign fwd_xfer = (state == FWD_S) && g_valid && eng_ready_i;
  assign out_last = eng_valid_i && src_ready_i && eng_endofpacket_i;

  // Round-robin search starting one past the previous owner, modulo N_CH so
  // non-power-of-two channel counts wrap correctly.
  always_comb begin : rr_pick
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_grant) + k) % N_CH;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state      <= IDLE_S;
      grant_o    <= '0;
      last_grant <= LAST_CH;
      cnt        <= '0;
      trunc_o    <= 1'b0;
    end else begin
      trunc_o <= 1'b0;
      case (state)
        IDLE_S: begin
          if (found) begin
            grant_o <= winner;
            state   <= FWD_S;
          end
        end
        FWD_S: begin
          if (fwd_xfer) begin
            cnt <= cnt + 1'b1;
            // A genuine eop on the last allowed word is not a truncation.
            if (g_eop) begin
              state <= DRAIN_S;
            end else if (cnt == LAST_IDX) begin
              trunc_o <= 1'b1;
              state   <= DROP_S;
            end
          end
        end
        DROP_S: begin
          if (g_valid && g_eop) begin
            state <= DRAIN_S;
          end
        end
        DRAIN_S: begin
          if (out_last) begin
            last_grant <= grant_o;
            cnt        <= '0;
            state      <= IDLE_S;
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end

  // Handshake outputs are forced low while reset is asserted, including the
  // first reset cycle before the state register has been cleared.
  always_comb begin
    req_ready_o         = '0;
    eng_valid_o         = 1'b0;
    eng_data_o          = req_data_i[int'(grant_o)*DWIDTH +: DWIDTH];
    eng_startofpacket_o = 1'b0;
    eng_endofpacket_o   = 1'b0;
    eng_ready_o         = 1'b0;
    src_valid_o         = 1'b0;
    src_startofpacket_o = 1'b0;
    src_endofpacket_o   = 1'b0;
    if (srst_i) begin
      case (state)
        IDLE_S: begin
          // Stray mid-packet words are flushed while nobody owns the engine.
          req_ready_o = req_valid_i & ~req_startofpacket_i;
        end
        FWD_S: begin
          eng_valid_o          = g_valid;
          req_ready_o[grant_o] = eng_ready_i;
          eng_startofpacket_o  = (cnt == '0);
          eng_endofpacket_o    = g_eop || (cnt == LAST_IDX);
        end
        DROP_S: begin
          req_ready_o[grant_o] = 1'b1;
        end
        DRAIN_S: begin
          eng_ready_o         = src_ready_i;
          src_valid_o         = eng_valid_i;
          src_startofpacket_o = eng_startofpacket_i;
          src_endofpacket_o   = eng_endofpacket_i;
        end
        default: ;
      endcase
    end
  end

  assign src_data_o    = eng_data_i;
  assign src_channel_o = grant_o;
  assign busy_o        = (state != IDLE_S);

endmodule

// File: tb/tb_sort_sched.sv
// tb_sort_sched: directed bench for sort_sched. The bench plays the requesters,
// the sort engine and the downstream sink in one thread. Inputs are driven
// just after the falling edge and outputs are sampled 1 time unit later.
module tb_sort_sched;
  localparam int N_CH   = 4;
  localparam int DWIDTH = 8;
  localparam int MAXP   = 1024;
  localparam int CH_W   = 2;

  logic                   clk = 1'b0;
  logic                   srst_i;
  logic [N_CH*DWIDTH-1:0] req_data_i;
  logic [N_CH-1:0]        req_startofpacket_i, req_endofpacket_i, req_valid_i, req_ready_o;
  logic [DWIDTH-1:0]      eng_data_o, eng_data_i, src_data_o;
  logic                   eng_startofpacket_o, eng_endofpacket_o, eng_valid_o, eng_ready_i;
  logic                   eng_startofpacket_i, eng_endofpacket_i, eng_valid_i, eng_ready_o;
  logic                   src_startofpacket_o, src_endofpacket_o, src_valid_o, src_ready_i;
  logic [CH_W-1:0]        src_channel_o, grant_o;
  logic                   busy_o, trunc_o;

  always #5 clk = ~clk;

  sort_sched #(.N_CH(N_CH), .DWIDTH(DWIDTH), .MAX_PKT_LEN(MAXP)) dut (
    .clk_i(clk), .srst_i(srst_i),
    .req_data_i(req_data_i), .req_startofpacket_i(req_startofpacket_i),
    .req_endofpacket_i(req_endofpacket_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .eng_data_o(eng_data_o), .eng_startofpacket_o(eng_startofpacket_o),
    .eng_endofpacket_o(eng_endofpacket_o), .eng_valid_o(eng_valid_o),
    .eng_ready_i(eng_ready_i),
    .eng_data_i(eng_data_i), .eng_startofpacket_i(eng_startofpacket_i),
    .eng_endofpacket_i(eng_endofpacket_i), .eng_valid_i(eng_valid_i),
    .eng_ready_o(eng_ready_o),
    .src_data_o(src_data_o), .src_startofpacket_o(src_startofpacket_o),
    .src_endofpacket_o(src_endofpacket_o), .src_valid_o(src_valid_o),
    .src_channel_o(src_channel_o), .src_ready_i(src_ready_i),
    .grant_o(grant_o), .busy_o(busy_o), .trunc_o(trunc_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  logic [7:0] pkt [0:1100];
  int         plen;
  logic [7:0] cap [0:1100];
  logic       cap_sop [0:1100];
  logic       cap_eop [0:1100];
  int         ncap, ntrunc;
  logic [7:0] ew [0:1100];
  int         elen;
  logic       rpat [0:3];
  int         rlen;

  // Drive pkt[0:plen-1] on channel ch; record every beat the engine accepts.
  task automatic send_pkt(input int ch);
    int i;
    int cyc;
    i = 0; cyc = 0; ncap = 0; ntrunc = 0;
    while (i < plen && cyc < 5000) begin
      req_valid_i[ch]                 = 1'b1;
      req_data_i[ch*DWIDTH +: DWIDTH] = pkt[i];
      req_startofpacket_i[ch]         = (i == 0);
      req_endofpacket_i[ch]           = (i == plen - 1);
      #1;
      if (trunc_o) ntrunc++;
      if (req_ready_o[ch]) begin
        if (eng_valid_o) begin
          cap[ncap]     = eng_data_o;
          cap_sop[ncap] = eng_startofpacket_o;
          cap_eop[ncap] = eng_endofpacket_o;
          ncap++;
        end
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("send_words_accepted", i, plen);
    req_valid_i[ch]         = 1'b0;
    req_startofpacket_i[ch] = 1'b0;
    req_endofpacket_i[ch]   = 1'b0;
  endtask

  // Engine returns ew[0:elen-1]; downstream ready follows rpat cyclically.
  task automatic emit(input int ch);
    int  j;
    int  k;
    logic r;
    j = 0; k = 0;
    while (j < elen && k < 5000) begin
      r                   = rpat[k % rlen];
      eng_valid_i         = 1'b1;
      eng_data_i          = ew[j];
      eng_startofpacket_i = (j == 0);
      eng_endofpacket_i   = (j == elen - 1);
      src_ready_i         = r;
      #1;
      chk("drain_req_ready", req_ready_o, 0);
      chk("drain_src_valid", src_valid_o, 1);
      chk("drain_eng_ready", eng_ready_o, r);
      if (r) begin
        chk("src_data", src_data_o, ew[j]);
        chk("src_channel", src_channel_o, ch);
        chk("src_sop", src_startofpacket_o, (j == 0));
        chk("src_eop", src_endofpacket_o, (j == elen - 1));
        j++;
      end
      k++;
      @(negedge clk);
    end
    chk("emit_words_delivered", j, elen);
    eng_valid_i = 1'b0; eng_startofpacket_i = 1'b0; eng_endofpacket_i = 1'b0;
    src_ready_i = 1'b0;
    #1;
    chk("busy_after_out_eop", busy_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int neop;
    srst_i = 1'b0; eng_ready_i = 1'b1; src_ready_i = 1'b0;
    req_data_i = '0; req_startofpacket_i = '0; req_endofpacket_i = '0;
    req_valid_i = 4'b0010;
    eng_data_i = '0; eng_startofpacket_i = 1'b0; eng_endofpacket_i = 1'b0; eng_valid_i = 1'b0;
    rpat[0] = 1'b1; rlen = 1;

    // Reset state, with a stray word present that must not be readied.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_eng_valid", eng_valid_o, 0);
    chk("rst_src_valid", src_valid_o, 0);
    chk("rst_eng_ready", eng_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_trunc", trunc_o, 0);
    req_valid_i = '0;
    srst_i = 1'b1;
    @(negedge clk);

    // Round robin: ch0 and ch2 request together -> 0, 2, then 0 again.
    req_valid_i = 4'b0101; req_startofpacket_i = 4'b0101; req_endofpacket_i = 4'b0100;
    req_data_i[0 +: 8] = 8'd4; req_data_i[16 +: 8] = 8'd1;
    #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_sop_not_ready", req_ready_o, 0);
    @(negedge clk); #1;
    chk("rr_grant_first", grant_o, 0);
    chk("rr_busy", busy_o, 1);
    chk("rr_other_not_ready", req_ready_o[2], 0);
    pkt[0] = 8'd4; pkt[1] = 8'd2; plen = 2;
    send_pkt(0);
    chk("rr0_ncap", ncap, 2);
    chk("rr0_w0", cap[0], 4);
    chk("rr0_w1", cap[1], 2);
    chk("rr0_sop", cap_sop[0], 1);
    chk("rr0_eop0", cap_eop[0], 0);
    chk("rr0_eop1", cap_eop[1], 1);
    req_valid_i[0] = 1'b1; req_startofpacket_i[0] = 1'b1; req_data_i[0 +: 8] = 8'd6;
    ew[0] = 8'd2; ew[1] = 8'd4; elen = 2;
    emit(0);
    @(negedge clk); #1;
    chk("rr_grant_second", grant_o, 2);
    pkt[0] = 8'd1; plen = 1;
    send_pkt(2);
    chk("rr2_ncap", ncap, 1);
    chk("rr2_sop", cap_sop[0], 1);
    chk("rr2_eop", cap_eop[0], 1);
    ew[0] = 8'd1; elen = 1;
    emit(2);
    @(negedge clk); #1;
    chk("rr_grant_third", grant_o, 0);
    pkt[0] = 8'd6; pkt[1] = 8'd5; plen = 2;
    send_pkt(0);
    ew[0] = 8'd5; ew[1] = 8'd6; elen = 2;
    emit(0);

    // ch1 five-word packet, returned sorted.
    pkt[0] = 8'd9; pkt[1] = 8'd3; pkt[2] = 8'd7; pkt[3] = 8'd1; pkt[4] = 8'd5; plen = 5;
    send_pkt(1);
    chk("p1_grant", grant_o, 1);
    chk("p1_ncap", ncap, 5);
    for (int i = 0; i < 5; i++) chk("p1_eng_data", cap[i], pkt[i]);
    chk("p1_sop", cap_sop[0], 1);
    chk("p1_mid_sop", cap_sop[2], 0);
    chk("p1_eop", cap_eop[4], 1);
    chk("p1_no_trunc", ntrunc, 0);
    ew[0] = 8'd1; ew[1] = 8'd3; ew[2] = 8'd5; ew[3] = 8'd7; ew[4] = 8'd9; elen = 5;
    emit(1);

    // Downstream backpressure 1,0,0,1 while ch3 waits with a sop.
    pkt[0] = 8'd8; pkt[1] = 8'd8; pkt[2] = 8'd3; plen = 3;
    send_pkt(0);
    chk("bp_grant", grant_o, 0);
    req_valid_i[3] = 1'b1; req_startofpacket_i[3] = 1'b1;
    rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1; rlen = 4;
    ew[0] = 8'd3; ew[1] = 8'd8; ew[2] = 8'd8; elen = 3;
    emit(0);
    rlen = 1;

    // ch3 over-long packet: truncated at MAXP words, rest dropped.
    for (int i = 0; i < MAXP + 3; i++) pkt[i] = 8'(i % 256);
    plen = MAXP + 3;
    send_pkt(3);
    chk("tr_grant", grant_o, 3);
    chk("tr_ncap", ncap, MAXP);
    chk("tr_sop", cap_sop[0], 1);
    chk("tr_last_eop", cap_eop[MAXP-1], 1);
    chk("tr_last_data", cap[MAXP-1], 8'd255);
    neop = 0;
    for (int i = 0; i < MAXP; i++) if (cap_eop[i]) neop++;
    chk("tr_eop_count", neop, 1);
    chk("tr_pulses", ntrunc, 1);
    chk("tr_busy_drain", busy_o, 1);
    for (int i = 0; i < MAXP; i++) ew[i] = 8'(i / 4);
    elen = MAXP;
    emit(3);

    // Stray words without sop on ch2 are flushed in IDLE_S, no grant.
    req_valid_i[2] = 1'b1; req_startofpacket_i[2] = 1'b0; req_data_i[16 +: 8] = 8'hAA;
    #1;
    chk("flush1_ready", req_ready_o, 4'b0100);
    chk("flush1_busy", busy_o, 0);
    @(negedge clk);
    req_data_i[16 +: 8] = 8'hBB;
    #1;
    chk("flush2_ready", req_ready_o, 4'b0100);
    @(negedge clk);
    req_valid_i[2] = 1'b0;
    #1;
    chk("flush_no_grant_busy", busy_o, 0);
    chk("flush_grant_kept", grant_o, 3);
    pkt[0] = 8'h22; pkt[1] = 8'h11; plen = 2;
    send_pkt(2);
    chk("flush_then_grant", grant_o, 2);
    chk("flush_then_ncap", ncap, 2);
    ew[0] = 8'h11; ew[1] = 8'h22; elen = 2;
    emit(2);

    // Reset in the middle of FWD_S.
    req_valid_i[1] = 1'b1; req_startofpacket_i[1] = 1'b1; req_data_i[8 +: 8] = 8'd1;
    @(negedge clk); #1;
    chk("mid_grant", grant_o, 1);
    @(negedge clk);
    req_startofpacket_i[1] = 1'b0; req_data_i[8 +: 8] = 8'd2;
    @(negedge clk);
    srst_i = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready_o, 0);
    chk("mid_rst_eng_valid", eng_valid_o, 0);
    @(negedge clk); #1;
    chk("mid_rst_grant", grant_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_src_valid", src_valid_o, 0);
    chk("mid_rst_eng_ready", eng_ready_o, 0);
    chk("mid_rst_trunc", trunc_o, 0);
    srst_i = 1'b1;
    req_valid_i = 4'b1001; req_startofpacket_i = 4'b1001; req_endofpacket_i = 4'b0001;
    req_data_i[0 +: 8] = 8'd7;
    @(negedge clk); #1;
    chk("post_rst_grant", grant_o, 0);
    pkt[0] = 8'd7; plen = 1;
    send_pkt(0);
    chk("post_rst_sop", cap_sop[0], 1);
    chk("post_rst_eop", cap_eop[0], 1);
    ew[0] = 8'd7; elen = 1;
    emit(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sort_sched.md
Name: sort_sched

Overview:
- Packet-level scheduler that shares one sort engine among N_CH Avalon-ST requesters.
- Picks one requester per packet by round-robin and streams its packet into the engine.
- Holds further grants until the engine has fully emitted the sorted packet, then returns it on a single output stream tagged with the requester's channel number.
- Sits between the per-channel packet sources and the sort engine's snk/src ports.

Parameters:
- N_CH, 4, number of requesters (>=2).
- DWIDTH, 8, data word width.
- MAX_PKT_LEN, 1024, maximum words per packet accepted by the engine.
- CH_W, $clog2(N_CH), channel index width (derived, not overridable).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- srst_i  in  1  synchronous reset, active-low (0 = reset).
- req_data_i  in  N_CH*DWIDTH  requester data, channel i at bits [i*DWIDTH +: DWIDTH].
- req_startofpacket_i  in  N_CH  per-channel sop.
- req_endofpacket_i  in  N_CH  per-channel eop.
- req_valid_i  in  N_CH  per-channel valid.
- req_ready_o  out  N_CH  per-channel ready.
- eng_data_o / eng_startofpacket_o / eng_endofpacket_o / eng_valid_o  out  DWIDTH/1/1/1  stream into the engine sink.
- eng_ready_i  in  1  engine sink ready.
- eng_data_i / eng_startofpacket_i / eng_endofpacket_i / eng_valid_i  in  DWIDTH/1/1/1  sorted stream from the engine.
- eng_ready_o  out  1  ready toward the engine source.
- src_data_o / src_startofpacket_o / src_endofpacket_o / src_valid_o  out  DWIDTH/1/1/1  output stream (combinational from the engine).
- src_channel_o  out  CH_W  channel owning the current output packet.
- src_ready_i  in  1  downstream ready.
- grant_o  out  CH_W  registered current grant.
- busy_o  out  1  1 when the FSM is not in IDLE_S.
- trunc_o  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
Transfer rule:
- A beat transfers when valid && ready in the same cycle on that interface.

Reset (srst_i == 0, evaluated at the clock edge):
- state = IDLE_S, grant_o = 0, last_grant = N_CH-1 (channel 0 wins first), word counter = 0, trunc_o = 0.
- All ready/valid outputs = 0 during reset.
- Reset mid-packet aborts without completing any stream. The engine shares the reset.

FSM states: IDLE_S, FWD_S, DROP_S, DRAIN_S.

IDLE_S:
- Candidates are channels with req_valid_i && req_startofpacket_i.
- The winner is the first candidate searching last_grant+1, last_grant+2, ... with modulo N_CH wrap.
- Registered into grant_o; next state FWD_S. With no candidate, stay in IDLE_S.
- Channels with valid && !sop get req_ready_o = 1, so stray mid-packet words are flushed and discarded. All other ready = 0, eng_valid_o = 0.
- Grant-to-first-beat latency is 1 cycle.

FWD_S (granted channel g only):
- eng_valid_o = req_valid_i[g], req_ready_o[g] = eng_ready_i, eng_data_o = channel g data.
- eng_startofpacket_o = (cnt == 0). A requester sop arriving mid-packet is ignored.
- Other channels: ready = 0.
- cnt increments per transferred beat.
- Transfer with eop: next state DRAIN_S.
- Transfer with cnt == MAX_PKT_LEN-1 and no eop: eng_endofpacket_o is forced to 1 on that beat, trunc_o pulses in the next cycle, next state DROP_S.
- If both conditions hold on the same beat, the eop wins and there is no truncation.

DROP_S:
- req_ready_o[g] = 1, eng_valid_o = 0, words discarded.
- On a transfer with eop: next state DRAIN_S.

DRAIN_S:
- src_* = eng_*, eng_ready_o = src_ready_i, src_channel_o = grant_o, held stable.
- No requester is readied.
- On an engine beat transferred with eng_endofpacket_i: last_grant = g, cnt = 0, next state IDLE_S.
- The next grant can occur in the IDLE_S cycle immediately after.

Outside DRAIN_S:
- src_valid_o = 0, eng_ready_o = 0.
- src_channel_o = grant_o.

Widths:
- cnt is $clog2(MAX_PKT_LEN+1) bits and never wraps.
- Grant arithmetic is modulo N_CH, including non-power-of-two N_CH.

Test Plan:
- Reset then ch0 and ch2 both present sop at the same time -> ch0 granted (grant_o = 0). After its output eop, ch2 is granted. Then ch0 again if pending: round-robin 0,2,0.
- ch1 sends 5-word packet {9,3,7,1,5}, engine model returns {1,3,5,7,9} -> src_channel_o = 1 for all 5 beats, sop on word 1, eop on word 5, busy_o = 0 one cycle after the eop transfer.
- ch3 sends MAX_PKT_LEN+3 words -> engine receives exactly MAX_PKT_LEN words with eop on the last, trunc_o pulses once, the remaining 3 words are consumed with no eng_valid_o, then DRAIN_S.
- In DRAIN_S, src_ready_i toggles 1,0,0,1 and a requester raises sop -> no data loss or duplication, req_ready_o stays 0 until IDLE_S.
- ch2 asserts valid without sop for 2 words in IDLE_S -> both flushed (ready = 1), no grant. A following sop is granted normally.
- srst_i driven low mid-FWD_S, released -> all outputs 0, grant_o = 0, next grant goes to channel 0.
